spool_bus_if: RTL and testbench

//  CPU-side bus front end for the block-RAM spooler register file. It synchronises the async CPU bus strobes
//  (cs_n/rd_n/wr_n, A[3:0], D[7:0]) into clk_i and emits exactly one single-cycle rd_o/wr_o pulse per bus cycle.

---
 rtl/spool_pkg.sv | 22 ++
 rtl/sync_bit.sv | 23 ++
 rtl/spool_bus_if.sv | 131 +++++++++++++
 tb/tb_spool_bus_if.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spool_pkg.sv
// rtl/spool_pkg.sv - shared types and register map for the spooler CPU bus front end
package spool_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_DRIVE,
    ST_WR_ISSUE,
    ST_HOLD
  } spool_bus_state_t;

  localparam logic [3:0] REG_ADDR_LO = 4'd0;
  localparam logic [3:0] REG_ADDR_HI = 4'd1;
  localparam logic [3:0] REG_DATA    = 4'd8;
  localparam logic [3:0] REG_CTRL    = 4'd15;

  localparam int REG_CTRL_RD    = 0;
  localparam int REG_CTRL_WR    = 1;
  localparam int REG_CTRL_ABORT = 7;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchroniser for one async strobe, resets to the inactive (high) level
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      chain_q <= '1;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/spool_bus_if.sv
// rtl/spool_bus_if.sv - CPU bus front end: synchronises strobes and issues one rd/wr pulse per bus cycle
module spool_bus_if #(
  parameter int SYNC_STAGES = 2,
  parameter int READ_LAT    = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cpu_cs_n_i,
  input  logic       cpu_rd_n_i,
  input  logic       cpu_wr_n_i,
  input  logic [3:0] cpu_a_i,
  input  logic [7:0] cpu_d_i,
  output logic [7:0] cpu_d_o,
  output logic       cpu_d_oe_o,
  output logic       cpu_wait_n_o,
  output logic [3:0] A_o,
  output logic [7:0] D_o,
  input  logic [7:0] D_i,
  output logic       rd_o,
  output logic       wr_o
);

  import spool_pkg::*;

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  logic cs_s, rd_s, wr_s;
  logic sel_rd, sel_wr, sel_both;

  spool_bus_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rd_q, wr_q, oe_q, wait_n_q;
  logic [7:0]       dout_q, d_q;
  logic [3:0]       a_q;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(cpu_cs_n_i), .q_o(cs_s)
  );
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(cpu_rd_n_i), .q_o(rd_s)
  );
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(cpu_wr_n_i), .q_o(wr_s)
  );

  // Address/data are sampled raw: the CPU holds them stable for the whole strobe window.
  assign sel_rd   = ~cs_s & ~rd_s &  wr_s;
  assign sel_wr   = ~cs_s & ~wr_s &  rd_s;
  assign sel_both = ~cs_s & ~rd_s & ~wr_s;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      oe_q     <= 1'b0;
      wait_n_q <= 1'b1;
      dout_q   <= '0;
      a_q      <= '0;
      d_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (sel_wr) begin
            a_q     <= cpu_a_i;
            d_q     <= cpu_d_i;
            wr_q    <= 1'b1;
            state_q <= ST_WR_ISSUE;
          end else if (sel_rd) begin
            a_q      <= cpu_a_i;
            rd_q     <= 1'b1;
            wait_n_q <= 1'b0;
            state_q  <= ST_RD_ISSUE;
          end else if (sel_both) begin
            state_q <= ST_HOLD;
          end
        end
        ST_WR_ISSUE: begin
          wr_q    <= 1'b0;
          state_q <= ST_HOLD;
        end
        ST_RD_ISSUE: begin
          rd_q <= 1'b0;
          if (cs_s) begin
            wait_n_q <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q   <= CNT_W'(READ_LAT - 1);
            state_q <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          // A deselect while waiting abandons the read; the bus is never driven.
          if (cs_s) begin
            wait_n_q <= 1'b1;
            state_q  <= ST_IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            dout_q   <= D_i;
            oe_q     <= 1'b1;
            wait_n_q <= 1'b1;
            state_q  <= ST_RD_DRIVE;
          end
        end
        ST_RD_DRIVE: begin
          if (cs_s | rd_s) begin
            oe_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (cs_s & rd_s & wr_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_o         = rd_q;
  assign wr_o         = wr_q;
  assign A_o          = a_q;
  assign D_o          = d_q;
  assign cpu_d_o      = dout_q;
  assign cpu_d_oe_o   = oe_q;
  assign cpu_wait_n_o = wait_n_q;

endmodule

// File: tb/tb_spool_bus_if.sv
// tb/tb_spool_bus_if.sv - directed bench with a timestamp-based bus model for spool_bus_if
module tb_spool_bus_if;

  localparam int SYNC = 2;
  localparam int LAT  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_cs_n = 1'b1, cpu_rd_n = 1'b1, cpu_wr_n = 1'b1;
  logic [3:0] cpu_a = '0;
  logic [7:0] cpu_d = '0;
  logic [7:0] spool_d = '0;
  logic [7:0] cpu_d_o, D_o;
  logic [3:0] A_o;
  logic       cpu_d_oe, cpu_wait_n, rd_o, wr_o;

  always #5 clk = ~clk;

  spool_bus_if #(.SYNC_STAGES(SYNC), .READ_LAT(LAT)) u_dut (
    .clk_i(clk), .reset_i(reset),
    .cpu_cs_n_i(cpu_cs_n), .cpu_rd_n_i(cpu_rd_n), .cpu_wr_n_i(cpu_wr_n),
    .cpu_a_i(cpu_a), .cpu_d_i(cpu_d),
    .cpu_d_o(cpu_d_o), .cpu_d_oe_o(cpu_d_oe), .cpu_wait_n_o(cpu_wait_n),
    .A_o(A_o), .D_o(D_o), .D_i(spool_d), .rd_o(rd_o), .wr_o(wr_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: the FSM sees each raw strobe SYNC edges after sampling; bus cycles tracked by edge timestamps.
  localparam int M_FREE = 0, M_READ = 1, M_DRIVE = 2, M_REL = 3;
  logic [2:0] hist [SYNC];
  logic [2:0] view;
  int         t = 0, mode = M_FREE, issue_t = 0, rel_from = 0;
  bit         started = 0;
  logic       e_rd, e_wr, e_oe, e_wait;
  logic [3:0] e_a;
  logic [7:0] e_d, e_dout;
  logic       cs_l, rd_l, wr_l;

  always @(posedge clk) begin
    t++;
    if (reset) begin
      for (int i = 0; i < SYNC; i++) hist[i] = 3'b111;
      e_rd = 0; e_wr = 0; e_oe = 0; e_wait = 1; e_a = '0; e_d = '0; e_dout = '0;
      mode = M_FREE;
      started = 1;
    end else begin
      view = hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {cpu_cs_n, cpu_rd_n, cpu_wr_n};
      cs_l = !view[2]; rd_l = !view[1]; wr_l = !view[0];
      e_rd = 0; e_wr = 0;
      case (mode)
        M_FREE: begin
          if (cs_l && wr_l && !rd_l) begin
            e_wr = 1; e_a = cpu_a; e_d = cpu_d; mode = M_REL; rel_from = t + 2;
          end else if (cs_l && rd_l && !wr_l) begin
            e_rd = 1; e_a = cpu_a; e_wait = 0; mode = M_READ; issue_t = t;
          end else if (cs_l && rd_l && wr_l) begin
            mode = M_REL; rel_from = t + 1;
          end
        end
        M_READ: begin
          if (!cs_l) begin
            e_wait = 1; mode = M_FREE;
          end else if (t == issue_t + 1 + LAT) begin
            e_dout = spool_d; e_oe = 1; e_wait = 1; mode = M_DRIVE;
          end
        end
        M_DRIVE: if (!cs_l || !rd_l) begin e_oe = 0; mode = M_FREE; end
        default: if (t >= rel_from && !cs_l && !rd_l && !wr_l) mode = M_FREE;
      endcase
    end
  end

  int rd_cnt = 0, wr_cnt = 0, wl_cnt = 0, oe_cnt = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("rd_o", rd_o, e_rd);
      chk("wr_o", wr_o, e_wr);
      chk("A_o", A_o, e_a);
      chk("D_o", D_o, e_d);
      chk("cpu_d_o", cpu_d_o, e_dout);
      chk("oe", cpu_d_oe, e_oe);
      chk("wait_n", cpu_wait_n, e_wait);
      if (rd_o) rd_cnt++;
      if (wr_o) wr_cnt++;
      if (!cpu_wait_n) wl_cnt++;
      if (cpu_d_oe) oe_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int k, j, base, base2;
  bit got;

  initial begin
    step(3);
    chk("reset_oe", cpu_d_oe, 0);
    chk("reset_wait", cpu_wait_n, 1);
    chk("reset_dout", cpu_d_o, 0);
    reset = 0;
    step(2);

    // 1: single write held for 10 cycles
    base = wr_cnt; base2 = wl_cnt;
    cpu_a = 4'd0; cpu_d = 8'h34; cpu_cs_n = 0; cpu_wr_n = 0;
    step(10);
    chk("t1_wr_pulses", wr_cnt - base, 1);
    chk("t1_A", A_o, 4'd0);
    chk("t1_D", D_o, 8'h34);
    chk("t1_wait_low", wl_cnt - base2, 0);
    cpu_cs_n = 1; cpu_wr_n = 1;
    step(5);

    // 2: read with latency measurement
    spool_d = 8'hA5; cpu_a = 4'd8; cpu_cs_n = 0; cpu_rd_n = 0;
    base = rd_cnt; base2 = wl_cnt;
    k = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(posedge clk); #1; k++; if (rd_o) got = 1; end
    chk("t2_rd_latency", k, SYNC + 1);
    chk("t2_wait_at_pulse", cpu_wait_n, 0);
    j = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(posedge clk); #1; j++; if (cpu_d_oe) got = 1; end
    chk("t2_oe_latency", j, LAT + 1);
    chk("t2_dout", cpu_d_o, 8'hA5);
    step(3);
    chk("t2_wait_cycles", wl_cnt - base2, LAT + 1);
    chk("t2_rd_pulses", rd_cnt - base, 1);
    cpu_rd_n = 1;
    j = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(posedge clk); #1; j++; if (!cpu_d_oe) got = 1; end
    chk("t2_oe_drop", (j >= 1 && j <= SYNC + 1), 1);
    cpu_cs_n = 1;
    step(4);

    // 3: back-to-back writes with a 3-cycle release
    base = wr_cnt;
    cpu_a = 4'd15; cpu_d = 8'h01; cpu_cs_n = 0; cpu_wr_n = 0;
    step(6);
    chk("t3_D_first", D_o, 8'h01);
    cpu_cs_n = 1; cpu_wr_n = 1;
    step(3);
    cpu_d = 8'h02; cpu_cs_n = 0; cpu_wr_n = 0;
    step(6);
    chk("t3_D_second", D_o, 8'h02);
    chk("t3_A", A_o, 4'd15);
    chk("t3_wr_pulses", wr_cnt - base, 2);
    cpu_cs_n = 1; cpu_wr_n = 1;
    step(4);

    // 4: illegal cycle, then a normal read
    base = rd_cnt + wr_cnt; base2 = oe_cnt;
    cpu_a = 4'd1; cpu_cs_n = 0; cpu_rd_n = 0; cpu_wr_n = 0;
    step(8);
    chk("t4_no_pulse", rd_cnt + wr_cnt - base, 0);
    chk("t4_no_oe", oe_cnt - base2, 0);
    cpu_cs_n = 1; cpu_rd_n = 1; cpu_wr_n = 1;
    step(4);
    spool_d = 8'h5A; cpu_cs_n = 0; cpu_rd_n = 0;
    step(10);
    chk("t4_read_oe", cpu_d_oe, 1);
    chk("t4_read_dout", cpu_d_o, 8'h5A);
    cpu_cs_n = 1; cpu_rd_n = 1;
    step(5);

    // 5: deselect while waiting for read data
    base2 = oe_cnt;
    spool_d = 8'hC3; cpu_a = 4'd8; cpu_cs_n = 0; cpu_rd_n = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(posedge clk); #1; if (rd_o) got = 1; end
    chk("t5_rd_seen", got, 1);
    cpu_cs_n = 1;
    step(8);
    chk("t5_no_oe", oe_cnt - base2, 0);
    chk("t5_wait_n", cpu_wait_n, 1);
    chk("t5_dout_kept", cpu_d_o, 8'h5A);
    cpu_rd_n = 1;
    step(3);
    base = wr_cnt;
    cpu_d = 8'h77; cpu_cs_n = 0; cpu_wr_n = 0;
    step(6);
    chk("t5_idle_write", wr_cnt - base, 1);
    cpu_cs_n = 1; cpu_wr_n = 1;
    step(4);

    // 6: reset during RD_DRIVE with the strobe still low
    spool_d = 8'h96; cpu_a = 4'd8; cpu_cs_n = 0; cpu_rd_n = 0;
    step(10);
    chk("t6_oe_before", cpu_d_oe, 1);
    base = rd_cnt;
    reset = 1;
    step(1);
    chk("t6_oe_reset", cpu_d_oe, 0);
    chk("t6_dout_reset", cpu_d_o, 0);
    chk("t6_wait_reset", cpu_wait_n, 1);
    reset = 0;
    step(10);
    chk("t6_new_pulse", rd_cnt - base, 1);
    chk("t6_oe_after", cpu_d_oe, 1);
    chk("t6_dout_after", cpu_d_o, 8'h96);
    cpu_cs_n = 1; cpu_rd_n = 1;
    step(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
